spi_adc_frame: RTL and testbench

- Downstream consumer of the sample-rate timer tick; one tick runs one SPI mode-0 (CPOL=0, CPHA=0), MSB-first, full-duplex frame to the bolometer ADC.
- Drives cs_n/sclk/mosi, captures miso into a parallel word, then presents that word with a one-cycle done strobe.
- Sits between the timer (start_i is driven by its zero-count output) and the sample storage/UART path.

---
 rtl/spi_adc_frame.sv | 180 ++++++++++++++++++
 tb/tb_spi_adc_frame.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_frame.sv
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first, full-duplex frame engine: one start_i runs one frame.
// Optional sticky overrun flag ovr_o is compiled in with `define SPI_FRAME_OVERRUN_EN.
module spi_adc_frame #(
   parameter int DataWidth  = 16,
   parameter int HalfPeriod = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [DataWidth-1:0] tx_data_i,
   input  logic                 miso_i,
   output logic                 sclk_o,
   output logic                 mosi_o,
   output logic                 cs_n_o,
   output logic [DataWidth-1:0] rx_data_o,
   output logic                 done_o,
   output logic                 busy_o
`ifdef SPI_FRAME_OVERRUN_EN
   ,
   output logic                 ovr_o
`endif
);

   localparam int PhW  = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
   localparam int BitW = $clog2(DataWidth + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SHIFT = 3'd2,
      TRAIL = 3'd3,
      GAP   = 3'd4
   } state_e;

   // Handshake: start_i is a level request taken only in IDLE (tx_data_i latched in that cycle);
   // busy_o covers the whole frame plus CS-high gap, and done_o marks rx_data_o as fresh.
   state_e               state_q, state_d;
   logic [PhW-1:0]       ph_q, ph_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DataWidth-1:0] tx_sr_q, tx_sr_d;
   logic [DataWidth-1:0] rx_sr_q, rx_sr_d;
   logic [DataWidth-1:0] rx_data_q, rx_data_d;
   logic [DataWidth-1:0] tx_shift, rx_shift;
   logic                 sclk_q, sclk_d;
   logic                 mosi_q, mosi_d;
   logic                 cs_n_q, cs_n_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 ph_last;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ph_last   = (ph_q == PhW'(HalfPeriod - 1));
      tx_shift  = tx_sr_q << 1;
      rx_shift  = (rx_sr_q << 1) | DataWidth'(miso_i);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = LEAD;
               tx_sr_d = tx_data_i;
               mosi_d  = tx_data_i[DataWidth-1];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               ph_d    = '0;
               bit_d   = '0;
            end
         end
         LEAD: begin
            if (ph_last) begin
               ph_d    = '0;
               sclk_d  = 1'b1;
               rx_sr_d = rx_shift;
               state_d = SHIFT;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         SHIFT: begin
            if (ph_last) begin
               ph_d = '0;
               if (sclk_q) begin
                  // Falling SCLK: present the next bit; zeros shift in, so mosi ends at 0.
                  sclk_d  = 1'b0;
                  tx_sr_d = tx_shift;
                  mosi_d  = tx_shift[DataWidth-1];
                  bit_d   = bit_q + 1'b1;
               end else if (bit_q == BitW'(DataWidth)) begin
                  state_d = TRAIL;
                  mosi_d  = 1'b0;
               end else begin
                  sclk_d  = 1'b1;
                  rx_sr_d = rx_shift;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         TRAIL: begin
            if (ph_last) begin
               ph_d      = '0;
               cs_n_d    = 1'b1;
               rx_data_d = rx_sr_q;
               done_d    = 1'b1;
               state_d   = GAP;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         GAP: begin
            if (ph_last) begin
               ph_d    = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SPI_FRAME_OVERRUN_EN
   logic ovr_q, ovr_d;
   assign ovr_d = ovr_q | (start_i & busy_q) | ((state_q == IDLE) & start_i & done_q);
   assign ovr_o = ovr_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ph_q      <= '0;
         bit_q     <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SPI_FRAME_OVERRUN_EN
         ovr_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
`ifdef SPI_FRAME_OVERRUN_EN
         ovr_q     <= ovr_d;
`endif
      end
   end

   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
   assign cs_n_o    = cs_n_q;
   assign rx_data_o = rx_data_q;
   assign done_o    = done_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_spi_adc_frame.sv
// Bench for spi_adc_frame: default instance (W=16, T=4) with an SPI slave model, plus a W=8, T=1 instance.
// Cycle n is sampled at the falling clk edge inside it; acceptance happens at the end of cycle 0.
module tb_spi_adc_frame;

   localparam int W  = 16;
   localparam int W8 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i, start_i, miso_i;
   logic [W-1:0]  tx_data_i, rx_data_o;
   logic          sclk_o, mosi_o, cs_n_o, done_o, busy_o;
   logic          start8, miso8;
   logic [W8-1:0] tx8, rx8;
   logic          sclk8, mosi8, cs8, done8, busy8;
`ifdef SPI_FRAME_OVERRUN_EN
   logic          ovr, ovr8;
`endif

   spi_adc_frame #(.DataWidth(W), .HalfPeriod(4)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .tx_data_i(tx_data_i), .miso_i(miso_i),
      .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o), .rx_data_o(rx_data_o),
      .done_o(done_o), .busy_o(busy_o)
`ifdef SPI_FRAME_OVERRUN_EN
      , .ovr_o(ovr)
`endif
   );

   spi_adc_frame #(.DataWidth(W8), .HalfPeriod(1)) u_dut8 (
      .clk_i(clk), .rst_i(rst_i), .start_i(start8), .tx_data_i(tx8), .miso_i(miso8),
      .sclk_o(sclk8), .mosi_o(mosi8), .cs_n_o(cs8), .rx_data_o(rx8),
      .done_o(done8), .busy_o(busy8)
`ifdef SPI_FRAME_OVERRUN_EN
      , .ovr_o(ovr8)
`endif
   );

   int n_cmp = 0;
   int n_mis = 0;
   logic [W-1:0]  exp_q[$];
   logic [W8-1:0] exp8_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Slave model: first bit ready at CS fall, next bit after each SCLK fall; MOSI captured on SCLK rise.
   logic [W-1:0]  slave_word, slv_sr, cap;
   logic [W8-1:0] cap8;
   int            rise_cnt, rise8;

   always @(negedge cs_n_o) begin
      slv_sr   = slave_word;
      miso_i   = slave_word[W-1];
      cap      = '0;
      rise_cnt = 0;
   end
   always @(negedge sclk_o) if (cs_n_o === 1'b0) begin
      slv_sr = slv_sr << 1;
      miso_i = slv_sr[W-1];
   end
   always @(posedge sclk_o) begin
      cap = {cap[W-2:0], mosi_o};
      rise_cnt++;
   end
   always @(negedge cs8) begin
      cap8  = '0;
      rise8 = 0;
   end
   always @(posedge sclk8) begin
      cap8 = {cap8[W8-2:0], mosi8};
      rise8++;
   end

   // Scoreboards: every done pulse pops the word the slave was told to return.
   always @(negedge clk) begin
      if (done_o === 1'b1) begin
         check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("sb_rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
      end
      if (done8 === 1'b1) begin
         check("sb8_pending", 32'(exp8_q.size() != 0), 32'd1);
         if (exp8_q.size() != 0) check("sb8_rx_data", 32'(rx8), 32'(exp8_q.pop_front()));
      end
   end

   int       first_low, last_low, first_busy, last_busy, done_cnt, min_gap, high_run;
   int       done_cyc[4];
   bit       seen_low;
   logic     snap_cs, snap_sclk, snap_busy, pre_ovr, pulse_ovr, snap_ovr;
   logic [W-1:0] snap_rx;

   // Called at the falling edge of cycle 0 with the DUT idle; runs ncyc cycles.
   task automatic run(input int ncyc, input bit hold, input int pulse_at, input int rst_at);
      first_low = -1; last_low = -1; first_busy = -1; last_busy = -1;
      done_cnt = 0; min_gap = 1000; high_run = 0; seen_low = 0;
      start_i = 1'b1;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (cs_n_o === 1'b0) begin
            if (first_low < 0) first_low = n;
            last_low = n;
            if (seen_low && high_run > 0 && high_run < min_gap) min_gap = high_run;
            seen_low = 1;
            high_run = 0;
         end else begin
            high_run++;
         end
         if (busy_o === 1'b1) begin
            if (first_busy < 0) first_busy = n;
            last_busy = n;
         end
         if (done_o === 1'b1) begin
            if (done_cnt < 4) done_cyc[done_cnt] = n;
            done_cnt++;
         end
         if (n == rst_at + 1) begin
            snap_cs = cs_n_o; snap_sclk = sclk_o; snap_busy = busy_o; snap_rx = rx_data_o;
         end
`ifdef SPI_FRAME_OVERRUN_EN
         if (n == pulse_at) pre_ovr = ovr;
         if (n == pulse_at + 1) pulse_ovr = ovr;
         if (n == rst_at + 1) snap_ovr = ovr;
`endif
         start_i = hold || (n == pulse_at);
         rst_i   = (n == rst_at);
         if (n == 1 && !hold) tx_data_i = W'($urandom_range(0, 32'hFFFF));
      end
   endtask

   int bad_cs, bad_sclk, bad_busy, bad_done, sclk_match, done8_cyc;

   initial begin
      rst_i = 1'b1; start_i = 1'b0; tx_data_i = '0; slave_word = '0;
      start8 = 1'b0; tx8 = '0; miso8 = 1'b0; miso_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;

      // Idle after reset
      bad_cs = 0; bad_sclk = 0; bad_busy = 0; bad_done = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (cs_n_o !== 1'b1) bad_cs++;
         if (sclk_o !== 1'b0) bad_sclk++;
         if (busy_o !== 1'b0) bad_busy++;
         if (done_o !== 1'b0) bad_done++;
      end
      check("idle_cs_n", 32'(bad_cs), 32'd0);
      check("idle_sclk", 32'(bad_sclk), 32'd0);
      check("idle_busy", 32'(bad_busy), 32'd0);
      check("idle_done", 32'(bad_done), 32'd0);
      check("idle_rx_data", 32'(rx_data_o), 32'h0000);
      check("idle_mosi", 32'(mosi_o), 32'd0);
`ifdef SPI_FRAME_OVERRUN_EN
      check("idle_ovr", 32'(ovr), 32'd0);
`endif

      // Single frame
      tx_data_i = 16'hA5C3; slave_word = 16'h3C96; exp_q.push_back(16'h3C96);
      run(150, 1'b0, -1, -1);
      check("f1_cs_first_low", 32'(first_low), 32'd1);
      check("f1_cs_last_low", 32'(last_low), 32'd136);
      check("f1_done_count", 32'(done_cnt), 32'd1);
      check("f1_done_cycle", 32'(done_cyc[0]), 32'd137);
      check("f1_busy_first", 32'(first_busy), 32'd1);
      check("f1_busy_last", 32'(last_busy), 32'd140);
      check("f1_sclk_pulses", 32'(rise_cnt), 32'd16);
      check("f1_mosi_word", 32'(cap), 32'hA5C3);
      check("f1_rx_held", 32'(rx_data_o), 32'h3C96);

      // Start pulse during a frame is dropped
      tx_data_i = 16'h5A5A; slave_word = 16'hC3A5; exp_q.push_back(16'hC3A5);
      run(150, 1'b0, 40, -1);
      check("pulse_done_count", 32'(done_cnt), 32'd1);
      check("pulse_done_cycle", 32'(done_cyc[0]), 32'd137);
      check("pulse_cs_last_low", 32'(last_low), 32'd136);
      check("pulse_busy_last", 32'(last_busy), 32'd140);
`ifdef SPI_FRAME_OVERRUN_EN
      check("ovr_before_pulse", 32'(pre_ovr), 32'd0);
      check("ovr_after_pulse", 32'(pulse_ovr), 32'd1);
      check("ovr_sticky", 32'(ovr), 32'd1);
`endif

      // Reset mid-frame, then a normal frame
      tx_data_i = 16'h1357; slave_word = 16'hBEEF;
      run(100, 1'b0, -1, 70);
      check("rst_cs_n", 32'(snap_cs), 32'd1);
      check("rst_sclk", 32'(snap_sclk), 32'd0);
      check("rst_busy", 32'(snap_busy), 32'd0);
      check("rst_rx_data", 32'(snap_rx), 32'h0000);
      check("rst_no_done", 32'(done_cnt), 32'd0);
`ifdef SPI_FRAME_OVERRUN_EN
      check("rst_ovr_clear", 32'(snap_ovr), 32'd0);
`endif
      tx_data_i = 16'h0F0F; slave_word = 16'h1234; exp_q.push_back(16'h1234);
      run(150, 1'b0, -1, -1);
      check("f2_done_cycle", 32'(done_cyc[0]), 32'd137);
      check("f2_mosi_word", 32'(cap), 32'h0F0F);
      check("f2_sclk_pulses", 32'(rise_cnt), 32'd16);

      // start_i held high: back-to-back frames, fourth one finishes after release
      tx_data_i = 16'h8001; slave_word = 16'h7E81;
      repeat (4) exp_q.push_back(16'h7E81);
      run(500, 1'b1, -1, -1);
      start_i = 1'b0;
      check("b2b_done_count", 32'(done_cnt), 32'd3);
      check("b2b_done_1", 32'(done_cyc[0]), 32'd137);
      check("b2b_done_2", 32'(done_cyc[1]), 32'd278);
      check("b2b_done_3", 32'(done_cyc[2]), 32'd419);
      check("b2b_cs_gap", 32'(min_gap), 32'd5);
      for (int k = 0; k < 300 && busy_o !== 1'b0; k++) @(negedge clk);
      @(negedge clk);
      check("b2b_drained_busy", 32'(busy_o), 32'd0);

      // HalfPeriod=1, W=8, tx all ones, miso tied low
      tx8 = 8'hFF; exp8_q.push_back(8'h00);
      start8 = 1'b1;
      sclk_match = 0; done8_cyc = -1;
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (n <= 18 && sclk8 === ((n >= 2 && n <= 17 && (n % 2) == 0) ? 1'b1 : 1'b0)) sclk_match++;
         if (done8 === 1'b1 && done8_cyc < 0) done8_cyc = n;
      end
      check("t1_sclk_pattern", 32'(sclk_match), 32'd18);
      check("t1_done_cycle", 32'(done8_cyc), 32'd19);
      check("t1_mosi_word", 32'(cap8), 32'hFF);
      check("t1_sclk_pulses", 32'(rise8), 32'd8);
      check("t1_rx_data", 32'(rx8), 32'h00);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("sb8_empty", 32'(exp8_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
